// File: rtl/instr_encoder_pkg.sv
// Encoder op set, RV32IM + Zicsr opcode/funct constants and field-packing helpers
// shared by the instruction encoder and its format packer.
package instr_encoder_pkg;

    localparam int XLEN     = 32;
    localparam int ENC_OP_W = 6;

    typedef enum logic [ENC_OP_W-1:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_ECALL, OP_EBREAK, OP_MRET, OP_FENCE, OP_LI
    } enc_op_e;

    localparam logic [6:0] R_TYPE     = 7'b0110011;
    localparam logic [6:0] I_TYPE     = 7'b0010011;
    localparam logic [6:0] L_TYPE     = 7'b0000011;
    localparam logic [6:0] S_TYPE     = 7'b0100011;
    localparam logic [6:0] B_TYPE     = 7'b1100011;
    localparam logic [6:0] U_TYPE     = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE = 7'b0010111;
    localparam logic [6:0] JAL_TYPE   = 7'b1101111;
    localparam logic [6:0] JALR_TYPE  = 7'b1100111;
    localparam logic [6:0] P_TYPE     = 7'b1110011;
    localparam logic [6:0] FENCE_TYPE = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_FENCE  = 32'h0FF0_000F;

    function automatic logic [2:0] op_funct3(input enc_op_e op);
        case (op)
            OP_SLL, OP_MULH, OP_SLLI, OP_LH, OP_SH, OP_BNE, OP_CSRRW:                  return 3'd1;
            OP_SLT, OP_MULHSU, OP_SLTI, OP_LW, OP_SW, OP_CSRRS:                        return 3'd2;
            OP_SLTU, OP_MULHU, OP_SLTIU, OP_CSRRC:                                     return 3'd3;
            OP_XOR, OP_DIV, OP_XORI, OP_LBU, OP_BLT:                                   return 3'd4;
            OP_SRL, OP_SRA, OP_DIVU, OP_SRLI, OP_SRAI, OP_LHU, OP_BGE, OP_CSRRWI:      return 3'd5;
            OP_OR, OP_REM, OP_ORI, OP_BLTU, OP_CSRRSI:                                 return 3'd6;
            OP_AND, OP_REMU, OP_ANDI, OP_BGEU, OP_CSRRCI:                              return 3'd7;
            default:                                                                   return 3'd0;
        endcase
    endfunction

    function automatic logic [6:0] op_funct7(input enc_op_e op);
        case (op)
            OP_SUB, OP_SRA, OP_SRAI:                                     return F7_ALT;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:                            return F7_MULDIV;
            default:                                                     return F7_BASE;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], S_TYPE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], B_TYPE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:12] upper, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {upper, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, JAL_TYPE};
    endfunction

endpackage

// File: rtl/instr_encoder_format_pack.sv
// Combinational packer: one symbolic op plus operands into a 32-bit RV32IM/Zicsr word,
// flagging immediates that do not fit the target format.
module instr_format_pack
    import instr_encoder_pkg::*;
(
    input  enc_op_e          op_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  instr_o,
    output logic             err_o
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       fits12;
    logic       shamt_ok;
    logic       b_ok;
    logic       j_ok;
    logic [31:0] word;
    logic        bad;

    assign f3       = op_funct3(op_i);
    assign f7       = op_funct7(op_i);
    assign fits12   = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign shamt_ok = (imm_i[31:5] == '0);
    assign b_ok     = !imm_i[0] && ((imm_i[31:12] == '0) || (imm_i[31:12] == '1));
    assign j_ok     = !imm_i[0] && ((imm_i[31:20] == '0) || (imm_i[31:20] == '1));

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                word = enc_r(f7, rs2_i, rs1_i, f3, rd_i, R_TYPE);
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                bad  = !fits12;
                word = enc_i(imm_i[11:0], rs1_i, f3, rd_i, I_TYPE);
            end
            OP_SLLI, OP_SRLI, OP_SRAI: begin
                bad  = !shamt_ok;
                word = enc_i({f7, imm_i[4:0]}, rs1_i, f3, rd_i, I_TYPE);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                bad  = !fits12;
                word = enc_i(imm_i[11:0], rs1_i, f3, rd_i, L_TYPE);
            end
            OP_JALR: begin
                bad  = !fits12;
                word = enc_i(imm_i[11:0], rs1_i, 3'd0, rd_i, JALR_TYPE);
            end
            OP_SB, OP_SH, OP_SW: begin
                bad  = !fits12;
                word = enc_s(imm_i[11:0], rs2_i, rs1_i, f3);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                bad  = !b_ok;
                word = enc_b(imm_i[12:1], rs2_i, rs1_i, f3);
            end
            OP_LUI, OP_AUIPC: begin
                bad  = (imm_i[11:0] != '0);
                word = enc_u(imm_i[31:12], rd_i, (op_i == OP_LUI) ? U_TYPE : AUIPC_TYPE);
            end
            OP_JAL: begin
                bad  = !j_ok;
                word = enc_j(imm_i[20:1], rd_i);
            end
            // CSR*I ops carry zimm in the rs1 slot, so all six share one layout.
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: begin
                bad  = (imm_i[31:12] != '0);
                word = enc_i(imm_i[11:0], rs1_i, f3, rd_i, P_TYPE);
            end
            OP_ECALL:  word = INSTR_ECALL;
            OP_EBREAK: word = INSTR_EBREAK;
            OP_MRET:   word = INSTR_MRET;
            OP_FENCE:  word = INSTR_FENCE;
            default:   bad  = 1'b1;
        endcase
    end

    assign instr_o = bad ? '0 : word;
    assign err_o   = bad;

endmodule

// File: rtl/instr_encoder.sv
// Symbolic micro-op to RV32 instruction word encoder with a registered output beat
// and a two-beat LUI+ADDI expansion of the LI pseudo-op.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ENC_OP_W-1:0] req_op_i,
    input  logic [4:0]          req_rd_i,
    input  logic [4:0]          req_rs1_i,
    input  logic [4:0]          req_rs2_i,
    input  logic [XLEN-1:0]     req_imm_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [XLEN-1:0]     instr_o,
    output logic                instr_last_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_LI_LO = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic [4:0]      li_rd_q, li_rd_d;
    logic [11:0]     li_lo_q, li_lo_d;

    enc_op_e         req_op;
    enc_op_e         pk_op;
    logic [4:0]      pk_rd, pk_rs1, pk_rs2;
    logic [XLEN-1:0] pk_imm;
    logic [XLEN-1:0] pk_instr;
    logic            pk_err;

    logic            accept, retire;
    logic            li_fits, li_two_beat;
    logic [31:12]    li_hi;

    assign req_op      = enc_op_e'(req_op_i);
    assign req_ready_o = (state_q == ST_IDLE) && (!valid_q || instr_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign retire      = valid_q && instr_ready_i;

    // Upper part is rounded so the sign-extended low 12 bits of ADDI land on imm.
    assign li_fits     = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
    assign li_hi       = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
    assign li_two_beat = (req_op == OP_LI) && !li_fits && (req_imm_i[11:0] != '0);

    always_comb begin
        pk_op  = req_op;
        pk_rd  = req_rd_i;
        pk_rs1 = req_rs1_i;
        pk_rs2 = req_rs2_i;
        pk_imm = req_imm_i;
        if (state_q == ST_LI_LO) begin
            pk_op  = OP_ADDI;
            pk_rd  = li_rd_q;
            pk_rs1 = li_rd_q;
            pk_rs2 = '0;
            pk_imm = {{20{li_lo_q[11]}}, li_lo_q};
        end else if (req_op == OP_LI) begin
            pk_rs1 = '0;
            pk_rs2 = '0;
            if (li_fits) begin
                pk_op = OP_ADDI;
            end else begin
                pk_op  = OP_LUI;
                pk_imm = {li_hi, 12'h000};
            end
        end
    end

    instr_format_pack u_pack (
        .op_i    (pk_op),
        .rd_i    (pk_rd),
        .rs1_i   (pk_rs1),
        .rs2_i   (pk_rs2),
        .imm_i   (pk_imm),
        .instr_o (pk_instr),
        .err_o   (pk_err)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        instr_d = instr_q;
        last_d  = last_q;
        err_d   = err_q;
        li_rd_d = li_rd_q;
        li_lo_d = li_lo_q;
        if (state_q == ST_LI_LO) begin
            if (retire) begin
                valid_d = 1'b1;
                instr_d = pk_instr;
                err_d   = pk_err;
                last_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = pk_instr;
            err_d   = pk_err;
            last_d  = pk_err || !li_two_beat;
            if (li_two_beat && !pk_err) begin
                state_d = ST_LI_LO;
                li_rd_d = req_rd_i;
                li_lo_d = req_imm_i[11:0];
            end
        end else if (retire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            instr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            li_rd_q <= '0;
            li_lo_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            li_rd_q <= li_rd_d;
            li_lo_q <= li_lo_d;
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_last_o  = last_q;
    assign err_o         = err_q;
    assign busy_o        = (state_q != ST_IDLE) || valid_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [ENC_OP_W-1:0] req_op_i;
    logic [4:0]          req_rd_i;
    logic [4:0]          req_rs1_i;
    logic [4:0]          req_rs2_i;
    logic [XLEN-1:0]     req_imm_i;
    logic                instr_valid_o;
    logic                instr_ready_i;
    logic [XLEN-1:0]     instr_o;
    logic                instr_last_o;
    logic                err_o;
    logic                busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_rd_i      (req_rd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_imm_i     (req_imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_last_o  (instr_last_o),
        .err_o         (err_o),
        .busy_o        (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input enc_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_rd_i    = rd;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        req_imm_i   = imm;
    endtask

    task automatic beat(input string tag, input logic [31:0] exp_instr,
                        input logic exp_last, input logic exp_err);
        check_eq({tag, ".valid"}, {31'd0, instr_valid_o}, 32'd1);
        check_eq({tag, ".instr"}, instr_o, exp_instr);
        check_eq({tag, ".last"},  {31'd0, instr_last_o}, {31'd0, exp_last});
        check_eq({tag, ".err"},   {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_op_i      = '0;
        req_rd_i      = '0;
        req_rs1_i     = '0;
        req_rs2_i     = '0;
        req_imm_i     = '0;
        instr_ready_i = 1'b1;
        repeat (2) tick();
        check_eq("rst.valid", {31'd0, instr_valid_o}, 32'd0);
        check_eq("rst.instr", instr_o, 32'd0);
        check_eq("rst.last",  {31'd0, instr_last_o}, 32'd0);
        check_eq("rst.err",   {31'd0, err_o}, 32'd0);
        check_eq("rst.busy",  {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst.ready", {31'd0, req_ready_o}, 32'd1);

        // Single-beat R-type
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        beat("add", 32'h0020_81B3, 1'b1, 1'b0);
        req_valid_i = 1'b0;
        tick();
        check_eq("add.retired", {31'd0, instr_valid_o}, 32'd0);

        // Two-beat LI; request fields change after acceptance and must be ignored
        send(OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        tick();
        beat("li1.b1", 32'h1234_52B7, 1'b0, 1'b0);
        check_eq("li1.ready_lo", {31'd0, req_ready_o}, 32'd0);
        check_eq("li1.busy",     {31'd0, busy_o}, 32'd1);
        req_valid_i = 1'b0;
        req_rd_i    = 5'd7;
        req_imm_i   = 32'hFFFF_FFFF;
        tick();
        beat("li1.b2", 32'h6782_8293, 1'b1, 1'b0);
        tick();
        check_eq("li1.done", {31'd0, instr_valid_o}, 32'd0);

        send(OP_LI, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        tick();
        beat("li2.b1", 32'h0000_10B7, 1'b0, 1'b0);
        req_valid_i = 1'b0;
        tick();
        beat("li2.b2", 32'h8000_8093, 1'b1, 1'b0);
        tick();

        send(OP_LI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        tick();
        beat("li3", 32'h8000_0093, 1'b1, 1'b0);
        req_valid_i = 1'b0;
        tick();

        // Backpressure then same-cycle retire and accept
        instr_ready_i = 1'b0;
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        send(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd5);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp.ready", {31'd0, req_ready_o}, 32'd0);
            check_eq("bp.hold",  instr_o, 32'h0020_81B3);
            tick();
        end
        instr_ready_i = 1'b1;
        #1;
        check_eq("bp.ready_on", {31'd0, req_ready_o}, 32'd1);
        tick();
        beat("bp.next", 32'h0050_0213, 1'b1, 1'b0);
        req_valid_i = 1'b0;
        tick();

        // Range errors and recovery, plus format boundaries
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
        tick();
        beat("beq.odd", 32'h0, 1'b1, 1'b1);
        send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32);
        tick();
        check_eq("slli32.err", {31'd0, err_o}, 32'd1);
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        beat("recover", 32'h0020_81B3, 1'b1, 1'b0);
        send(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd2047);
        tick();
        beat("addi.max", 32'h7FF0_0213, 1'b1, 1'b0);
        send(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd2048);
        tick();
        beat("addi.over", 32'h0, 1'b1, 1'b1);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd4);
        tick();
        beat("jal", 32'h0040_00EF, 1'b1, 1'b0);
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick();
        beat("beq.back", 32'hFE20_8EE3, 1'b1, 1'b0);
        req_valid_i = 1'b0;
        tick();

        // Reset while the first LI beat is stalled
        instr_ready_i = 1'b0;
        send(OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        tick();
        beat("rstli.b1", 32'h1234_52B7, 1'b0, 1'b0);
        req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rstli.valid_now", {31'd0, instr_valid_o}, 32'd0);
        tick();
        rst = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        check_eq("rstli.busy",  {31'd0, busy_o}, 32'd0);
        check_eq("rstli.ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        check_eq("rstli.no_b2", {31'd0, instr_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode stage: turns a symbolic micro-op request (op, rd, rs1, rs2, imm) into a 32-bit RV32IM + Zicsr instruction word.
- Used by the debug/trap sequencer and the self-test injector to feed instructions into the fetch-side instruction buffer.
- Valid/ready on both sides, one registered output beat.
- Expands the LI pseudo-op into LUI+ADDI through a small FSM.

Parameters:
- XLEN, 32, instruction and immediate width (from riscv_pkg).
- ENC_OP_W, 6, width of the encoder op field (enc_op_e).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  ENC_OP_W  enc_op_e operation
- req_rd_i  in  5  destination register
- req_rs1_i  in  5  source 1; zimm for CSR*I ops
- req_rs2_i  in  5  source 2
- req_imm_i  in  XLEN  immediate; CSR address in [11:0] for CSR ops
- instr_valid_o  out  1  output beat valid
- instr_ready_i  in  1  consumer ready
- instr_o  out  XLEN  encoded instruction
- instr_last_o  out  1  final beat of this request
- err_o  out  1  request not encodable; qualified by instr_valid_o
- busy_o  out  1  FSM not in IDLE or output register occupied

Behaviour:
- Reset (async, rst=1): instr_valid_o=0, instr_o=0, instr_last_o=0, err_o=0, busy_o=0, state=IDLE. req_ready_o is 1 once rst deasserts.
- Output register handshake:
  - Beat held stable (all outputs) while instr_valid_o=1 and instr_ready_i=0.
  - Beat retires on instr_valid_o & instr_ready_i.
- Acceptance: req_ready_o = (state==IDLE) & (~instr_valid_o | instr_ready_i).
  - Same-cycle retire and accept is allowed (full throughput, one instruction per cycle).
- Latency: accepted request appears on instr_o the next cycle.
- Field packing:
  - Standard RV32 R/I/S/B/U/J formats.
  - Opcode, funct3 and funct7 constants come from riscv_pkg (R_TYPE, I_TYPE, L_TYPE, S_TYPE, B_TYPE, U_TYPE, AUIPC_TYPE, JAL_TYPE, JALR_TYPE, P_TYPE, FENCE_TYPE).
- Range checks (violation -> error beat):
  - I/L/JALR/S imm: signed 12-bit (-2048..2047).
  - Shifts: imm 0..31.
  - B imm: even, -4096..4094.
  - JAL imm: even, +/-1 MiB.
  - LUI/AUIPC: imm[31:12] used, imm[11:0] must be 0.
  - CSR: imm[31:12] must be 0.
  - Unknown op: error.
- Error beat: instr_o=32'h0 (architecturally illegal), err_o=1, instr_last_o=1. The FSM does not advance.
- FSM states:
  - IDLE: normal single-beat ops; instr_last_o=1.
  - LI_LO: second LI beat pending.
- LI rd, imm:
  - If imm fits signed 12-bit: single beat ADDI rd,x0,imm, last=1.
  - Otherwise, beat 1: LUI rd,(imm+0x800)[31:12], last=0.
    - If imm[11:0]==0: beat 1 is LUI with last=1 and no second beat.
    - Else go to LI_LO; when beat 1 retires, load beat 2 ADDI rd,rd,sext(imm[11:0]) with last=1, then return to IDLE.
  - req_ready_o=0 throughout LI_LO.
  - rd captured at acceptance; later req_* changes are ignored.
- rst mid-LI: both beats dropped, state=IDLE, instr_valid_o=0.
- rd=x0 is legal and encoded as given.

Decomposition:
- riscv_pkg additions:
  - enc_op_e enum covering ADD..REMU, ADDI..SRAI, loads, stores, branches, LUI, AUIPC, JAL, JALR, CSRRW..CSRRCI, ECALL, EBREAK, MRET, FENCE, LI.
  - funct3/funct7 constants and the ECALL/EBREAK/MRET fixed encodings.
- One combinational sub-module, instr_format_pack: (op, rd, rs1, rs2, imm) -> {instr, err}.
  - The LI FSM reuses it for each beat by issuing LUI and ADDI requests to it.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, instr_ready_i=1 -> next cycle instr_o=0x002081B3, last=1, err=0.
- LI rd=5 imm=0x12345678 -> beat 0x123452B7 (last=0), then 0x67828293 (last=1); req_ready_o=0 between the beats.
- LI rd=1 imm=0x800 -> 0x000010B7 then 0x80008093. LI rd=1 imm=0xFFFFF800 -> single beat 0x80000093.
- Backpressure: ADD issued, instr_ready_i=0 for 3 cycles -> instr_o held, req_ready_o=0; on ready, a back-to-back request retires and the new one is accepted in the same cycle.
- Errors:
  - BEQ imm=3 -> instr_o=0, err_o=1, last=1.
  - SLLI imm=32 -> err_o=1.
  - Next valid request encodes normally.
- rst asserted after LI beat 1 is presented -> instr_valid_o=0 immediately, no second beat, busy_o=0 after release.
